multicycle_alu: RTL and testbench
=================================

Name: multicycle_alu

Overview:
- Parametrised, handshaked successor to the single-cycle datapath ALU.
- Adds signed and unsigned add/sub with correct overflow, arithmetic shift, and an iterative unsigned multiply/divide engine.
- Uses a valid/ready front end, so the control unit can stall on multi-cycle ops.
- Sits between the register file/immediate mux and the data-RAM address/writeback path.

Parameters:
- WIDTH, 32: operand and result width (>= 8).
- SHAMT_W, 5: shift-amount bits taken from operand_B[SHAMT_W-1:0]; must equal clog2(WIDTH).
- ADDR_W, 10: width of ram_address.

Ports:
- clk  in  1: clock.
- reset  in  1: synchronous, active-high reset.
- in_valid  in  1: operands and opcode valid.
- in_ready  out  1: unit can accept a new op.
- operand_A  in  WIDTH: first operand.
- operand_B  in  WIDTH: second operand / shift amount.
- alu_control  in  4: opcode.
- out_valid  out  1: one-cycle pulse when the result is valid.
- alu_result  out  WIDTH: registered result.
- zero_flag  out  1: alu_result == 0.
- overflow  out  1: signed overflow of the last ADD/SUB.
- ram_address  out  ADDR_W: alu_result[ADDR_W-1:0], zero-extended if WIDTH < ADDR_W.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on reset.
- Reset values:
  - FSM = IDLE.
  - in_ready = 1, out_valid = 0.
  - alu_result = 0, so zero_flag = 1 and ram_address = 0.
  - overflow = 0.
  - Iterative counters and accumulators cleared.
- Accept: an op is accepted on a clock edge where in_valid && in_ready. Operands and opcode are captured then; later input changes are ignored.
- Opcodes:
  - 0010 ADD: A+B mod 2^WIDTH; overflow = (A[msb]==B[msb]) && (R[msb]!=A[msb]).
  - 0011 SUB: A-B mod 2^WIDTH; overflow = (A[msb]!=B[msb]) && (R[msb]!=A[msb]).
  - 0100 AND, 0101 OR, 0110 XOR, 0111 NOT A, 1010 NOR.
  - 1000 SLL, 1001 SRL: logical shifts by B[SHAMT_W-1:0].
  - 1101 SRA: arithmetic shift right by B[SHAMT_W-1:0].
  - 1011 SUBU: A-B mod 2^WIDTH. 1100 ADDU: A+B mod 2^WIDTH. Neither touches overflow.
  - 1110 MULU: low WIDTH bits of unsigned A*B, shift-add, one bit per cycle.
  - 1111 DIVU: unsigned quotient A/B, restoring, one bit per cycle (see Optional Feature).
  - Any other opcode: result 0.
- overflow is written only on ADD/SUB completion and holds through all other ops.
- FSM:
  - IDLE: in_ready = 1.
    - Accept of a single-cycle op: result registered on the accept edge; out_valid = 1 the next cycle; stay IDLE.
    - Accept of MULU/DIVU: go to BUSY, counter = WIDTH.
  - BUSY: in_ready = 0; one iteration per cycle, counter decrements.
    - When counter reaches 1, the final iteration writes alu_result and out_valid pulses the following cycle; return to IDLE.
- Latency (accept edge to out_valid high):
  - Single-cycle ops: 1 cycle.
  - MULU/DIVU: WIDTH+1 cycles.
  - Back-to-back single-cycle ops give 1 op/cycle throughput.
- Divide by zero: quotient = all ones. Still takes WIDTH+1 cycles.
- Result holding: alu_result, zero_flag and ram_address hold their value between completions. They change only on the edge that raises out_valid.
- Shift amounts: SHAMT_W-bit shift amounts (0..WIDTH-1) are used as-is; no saturation.
- Reset mid-operation: reset during BUSY aborts the op. Next cycle is IDLE with in_ready = 1 and all reset values; no out_valid for the aborted op.
- Simultaneous events: in_valid while BUSY is not accepted, and the upstream holds its request. An out_valid pulse and a new accept in the same cycle are legal in IDLE.

Optional Feature:
- ALU_DIV_EN defined: opcode 1111 = iterative DIVU as above.
- ALU_DIV_EN undefined:
  - 1111 is treated as an undefined opcode: single-cycle, result 0, overflow untouched.
  - No divider hardware is generated; MULU is unaffected.

Test Plan:
- ADD with overflow: reset, then ADD A=0x7FFFFFFF B=0x00000001 -> after 1 cycle out_valid=1, alu_result=0x80000000, overflow=1, zero_flag=0.
- SUB/SUBU: SUB A=0x80000000 B=1 -> result 0x7FFFFFFF, overflow=1. Then SUBU A=3 B=3 -> result 0, zero_flag=1, overflow stays 1.
- Shifts: SRA A=0xF0000000 B=4 -> 0xFF000000. SRL with the same operands -> 0x0F000000. SLL A=1 B=0x25 -> 0x00000020 (low 5 bits of B used).
- MULU: A=0x00010001 B=0x00010001 -> in_ready=0 for 32 cycles, out_valid at accept+33, result 0x00020001. A second in_valid while BUSY is not accepted.
- DIVU (ALU_DIV_EN defined): A=100 B=7 -> result 14 at accept+33. A=5 B=0 -> result 0xFFFFFFFF. With the macro undefined, opcode 1111 gives result 0 after 1 cycle.
- Reset mid-MULU: assert reset at cycle 10 of BUSY -> next cycle in_ready=1, alu_result=0, zero_flag=1, and no out_valid pulse appears.

Source files
------------

// File: rtl/multicycle_alu_if.sv
// Handshake and result bundle between the operand source and the multicycle ALU.
// Latency: none. This file only groups wires.
// Backpressure: the slave drops in_ready while busy, and the master holds in_valid and its operands until accepted.
//
// Signals: in_valid/in_ready form the request handshake. operand_A, operand_B and alu_control are the request payload.
//          out_valid is a one-cycle completion pulse. alu_result, zero_flag, overflow and ram_address are held results.
// Modports: master drives the request side (register file / control unit); slave is the ALU.
interface multicycle_alu_if #(
    parameter int WIDTH  = 32,
    parameter int ADDR_W = 10
);
    logic              in_valid;
    logic              in_ready;
    logic [WIDTH-1:0]  operand_A;
    logic [WIDTH-1:0]  operand_B;
    logic [3:0]        alu_control;
    logic              out_valid;
    logic [WIDTH-1:0]  alu_result;
    logic              zero_flag;
    logic              overflow;
    logic [ADDR_W-1:0] ram_address;

    modport master (
        output in_valid, operand_A, operand_B, alu_control,
        input  in_ready, out_valid, alu_result, zero_flag, overflow, ram_address
    );

    modport slave (
        input  in_valid, operand_A, operand_B, alu_control,
        output in_ready, out_valid, alu_result, zero_flag, overflow, ram_address
    );
endinterface

// File: rtl/multicycle_alu.sv
// Handshaked ALU providing single-cycle logic, arithmetic and shift ops, plus an iterative unsigned multiply and divide.
// Latency: a single-cycle op raises out_valid one cycle after accept. MULU/DIVU raise out_valid WIDTH+1 cycles after the accept cycle.
// Backpressure: in_ready is low for the WIDTH iteration cycles of MULU/DIVU. In IDLE, one op is accepted per cycle.
//
// Ports: clk and reset are plain ports (synchronous, active-high reset). bus is a multicycle_alu_if.slave that carries the
//        handshake, operands, opcode and held results (alu_result, zero_flag, overflow, ram_address).
// Build option: define ALU_DIV_EN to include the restoring divider (opcode 1111). Without it, 1111 is an undefined opcode.
module multicycle_alu #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5,
    parameter int ADDR_W  = 10
) (
    input logic             clk,
    input logic             reset,
    multicycle_alu_if.slave bus
);
    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam int MSB   = WIDTH - 1;

    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_SUB  = 4'b0011;
    localparam logic [3:0] OP_AND  = 4'b0100;
    localparam logic [3:0] OP_OR   = 4'b0101;
    localparam logic [3:0] OP_XOR  = 4'b0110;
    localparam logic [3:0] OP_NOT  = 4'b0111;
    localparam logic [3:0] OP_SLL  = 4'b1000;
    localparam logic [3:0] OP_SRL  = 4'b1001;
    localparam logic [3:0] OP_NOR  = 4'b1010;
    localparam logic [3:0] OP_SUBU = 4'b1011;
    localparam logic [3:0] OP_ADDU = 4'b1100;
    localparam logic [3:0] OP_SRA  = 4'b1101;
    localparam logic [3:0] OP_MULU = 4'b1110;
`ifdef ALU_DIV_EN
    localparam logic [3:0] OP_DIVU = 4'b1111;
`endif

    typedef enum logic {
        IDLE,
        BUSY
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   count;
    logic [WIDTH-1:0]   work_a;   // MULU: shifted multiplicand; DIVU: dividend bits shifting out, quotient bits shifting in
    logic [WIDTH-1:0]   work_b;   // MULU: multiplier consumed LSB first; DIVU: divisor
    logic [WIDTH-1:0]   acc;      // MULU: partial product; DIVU: partial remainder
    logic [WIDTH-1:0]   result_q;
    logic               ovf_q;
    logic               in_ready_q;
    logic               out_valid_q;
`ifdef ALU_DIV_EN
    logic               is_div;
`endif

    // ---------------------------------------------------------------- single-cycle datapath
    logic [WIDTH-1:0]   op_a;
    logic [WIDTH-1:0]   op_b;
    logic [SHAMT_W-1:0] shamt;
    logic [WIDTH-1:0]   sum;
    logic [WIDTH-1:0]   diff;
    logic [WIDTH-1:0]   sc_result;
    logic               sc_ovf;
    logic               sc_wr_ovf;
    logic               start_iter;

    assign op_a  = bus.operand_A;
    assign op_b  = bus.operand_B;
    assign shamt = op_b[SHAMT_W-1:0];
    assign sum   = op_a + op_b;
    assign diff  = op_a - op_b;

    always_comb begin
        sc_result  = '0;
        sc_ovf     = 1'b0;
        sc_wr_ovf  = 1'b0;
        start_iter = 1'b0;
        case (bus.alu_control)
            OP_ADD: begin
                sc_result = sum;
                sc_wr_ovf = 1'b1;
                // Same-sign operands producing a result of the other sign.
                sc_ovf    = (op_a[MSB] == op_b[MSB]) && (sum[MSB] != op_a[MSB]);
            end
            OP_SUB: begin
                sc_result = diff;
                sc_wr_ovf = 1'b1;
                sc_ovf    = (op_a[MSB] != op_b[MSB]) && (diff[MSB] != op_a[MSB]);
            end
            OP_AND:  sc_result = op_a & op_b;
            OP_OR:   sc_result = op_a | op_b;
            OP_XOR:  sc_result = op_a ^ op_b;
            OP_NOT:  sc_result = ~op_a;
            OP_NOR:  sc_result = ~(op_a | op_b);
            OP_SLL:  sc_result = op_a << shamt;
            OP_SRL:  sc_result = op_a >> shamt;
            OP_SRA:  sc_result = unsigned'($signed(op_a) >>> shamt);
            OP_SUBU: sc_result = diff;
            OP_ADDU: sc_result = sum;
            OP_MULU: start_iter = 1'b1;
`ifdef ALU_DIV_EN
            OP_DIVU: start_iter = 1'b1;
`endif
            default: sc_result = '0;
        endcase
    end

    // ---------------------------------------------------------------- iterative datapath
    logic [WIDTH-1:0] mul_acc_nxt;
    assign mul_acc_nxt = work_b[0] ? (acc + work_a) : acc;

`ifdef ALU_DIV_EN
    logic [WIDTH:0]   rem_sh;
    logic [WIDTH:0]   rem_diff;
    logic             div_ge;
    logic [WIDTH-1:0] div_rem_nxt;
    logic [WIDTH-1:0] div_q_nxt;

    // Restoring step: bring in the next dividend bit, then try subtracting the divisor.
    // A zero divisor always "fits", so the quotient naturally saturates to all ones.
    assign rem_sh      = {acc, work_a[MSB]};
    assign rem_diff    = rem_sh - {1'b0, work_b};
    assign div_ge      = ~rem_diff[WIDTH];
    assign div_rem_nxt = div_ge ? rem_diff[WIDTH-1:0] : rem_sh[WIDTH-1:0];
    assign div_q_nxt   = {work_a[WIDTH-2:0], div_ge};
`endif

    // ---------------------------------------------------------------- control and state
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            count       <= '0;
            work_a      <= '0;
            work_b      <= '0;
            acc         <= '0;
            result_q    <= '0;
            ovf_q       <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
`ifdef ALU_DIV_EN
            is_div      <= 1'b0;
`endif
        end else begin
            out_valid_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        if (start_iter) begin
                            state      <= BUSY;
                            in_ready_q <= 1'b0;
                            count      <= CNT_W'(WIDTH);
                            work_a     <= op_a;
                            work_b     <= op_b;
                            acc        <= '0;
`ifdef ALU_DIV_EN
                            is_div     <= (bus.alu_control == OP_DIVU);
`endif
                        end else begin
                            result_q    <= sc_result;
                            out_valid_q <= 1'b1;
                            if (sc_wr_ovf) begin
                                ovf_q <= sc_ovf;
                            end
                        end
                    end
                end
                BUSY: begin
                    count <= count - CNT_W'(1);
`ifdef ALU_DIV_EN
                    if (is_div) begin
                        acc    <= div_rem_nxt;
                        work_a <= div_q_nxt;
                    end else begin
                        acc    <= mul_acc_nxt;
                        work_a <= work_a << 1;
                        work_b <= work_b >> 1;
                    end
`else
                    acc    <= mul_acc_nxt;
                    work_a <= work_a << 1;
                    work_b <= work_b >> 1;
`endif
                    // The last iteration goes straight into the result register, so out_valid lines up with it.
                    if (count == CNT_W'(1)) begin
`ifdef ALU_DIV_EN
                        result_q <= is_div ? div_q_nxt : mul_acc_nxt;
`else
                        result_q <= mul_acc_nxt;
`endif
                        out_valid_q <= 1'b1;
                        in_ready_q  <= 1'b1;
                        state       <= IDLE;
                    end
                end
                default: begin
                    state      <= IDLE;
                    in_ready_q <= 1'b1;
                end
            endcase
        end
    end

    // ---------------------------------------------------------------- outputs
    assign bus.in_ready   = in_ready_q;
    assign bus.out_valid  = out_valid_q;
    assign bus.alu_result = result_q;
    assign bus.zero_flag  = (result_q == '0);
    assign bus.overflow   = ovf_q;

    generate
        if (WIDTH >= ADDR_W) begin : g_addr_trunc
            assign bus.ram_address = result_q[ADDR_W-1:0];
        end else begin : g_addr_zext
            assign bus.ram_address = {{(ADDR_W-WIDTH){1'b0}}, result_q};
        end
    endgenerate
endmodule

// File: tb/tb_multicycle_alu.sv
// Bench for multicycle_alu: directed vectors with literal expectations, plus a per-cycle scoreboard model.
// Latency: the model expects out_valid 1 cycle after a single-cycle accept and WIDTH+1 cycles after a MULU/DIVU accept.
// Backpressure: the model treats the unit as not ready for WIDTH cycles after a multi-cycle accept.
module tb_multicycle_alu;
    localparam int W  = 32;
    localparam int AW = 10;

    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_SUB  = 4'b0011;
    localparam logic [3:0] OP_AND  = 4'b0100;
    localparam logic [3:0] OP_OR   = 4'b0101;
    localparam logic [3:0] OP_XOR  = 4'b0110;
    localparam logic [3:0] OP_NOT  = 4'b0111;
    localparam logic [3:0] OP_SLL  = 4'b1000;
    localparam logic [3:0] OP_SRL  = 4'b1001;
    localparam logic [3:0] OP_NOR  = 4'b1010;
    localparam logic [3:0] OP_SUBU = 4'b1011;
    localparam logic [3:0] OP_ADDU = 4'b1100;
    localparam logic [3:0] OP_SRA  = 4'b1101;
    localparam logic [3:0] OP_MULU = 4'b1110;
    localparam logic [3:0] OP_DIVU = 4'b1111;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    multicycle_alu_if #(.WIDTH(W), .ADDR_W(AW)) bus ();

    multicycle_alu #(.WIDTH(W), .SHAMT_W(5), .ADDR_W(AW)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h, want %0h", name, $time, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s at %0t: timed out waiting for the DUT", name, $time);
    endtask

    // Reference behaviour from the opcode definitions, using wide signed/unsigned arithmetic.
    function automatic void model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] r, output bit wr_ovf, output bit ovf, output bit multi);
        longint     s;
        logic [63:0] p;
        logic [4:0]  sh;
        sh = b[4:0];
        r = 32'h0; wr_ovf = 1'b0; ovf = 1'b0; multi = 1'b0;
        case (op)
            OP_ADD: begin
                s = longint'($signed(a)) + longint'($signed(b));
                r = s[31:0]; wr_ovf = 1'b1;
                ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            OP_SUB: begin
                s = longint'($signed(a)) - longint'($signed(b));
                r = s[31:0]; wr_ovf = 1'b1;
                ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            OP_AND:  r = a & b;
            OP_OR:   r = a | b;
            OP_XOR:  r = a ^ b;
            OP_NOT:  r = ~a;
            OP_NOR:  r = ~(a | b);
            OP_SLL:  r = a << sh;
            OP_SRL:  r = a >> sh;
            OP_SRA: begin
                r = a >> sh;
                if (a[31]) r = r | ~(32'hFFFF_FFFF >> sh);
            end
            OP_SUBU: r = a - b;
            OP_ADDU: r = a + b;
            OP_MULU: begin
                p = {32'h0, a} * {32'h0, b};
                r = p[31:0]; multi = 1'b1;
            end
`ifdef ALU_DIV_EN
            OP_DIVU: begin
                r = (b == 32'h0) ? 32'hFFFF_FFFF : a / b;
                multi = 1'b1;
            end
`endif
            default: r = 32'h0;
        endcase
    endfunction

    // Scoreboard: replays each clock edge against the model and compares all outputs.
    bit          m_live = 1'b0;
    int          m_busy = 0;
    logic [31:0] m_res = 32'h0;
    logic [31:0] m_pend = 32'h0;
    bit          m_ovf = 1'b0;
    bit          m_ov = 1'b0;
    logic [31:0] mr;
    bit          mwo, mo, mmu;

    initial forever begin
        @(posedge clk);
        #1;
        if (reset) begin
            m_live = 1'b1; m_busy = 0; m_res = 32'h0; m_ovf = 1'b0; m_ov = 1'b0;
        end else if (m_live) begin
            m_ov = 1'b0;
            if (m_busy > 0) begin
                m_busy--;
                if (m_busy == 0) begin
                    m_ov = 1'b1;
                    m_res = m_pend;
                end
            end else if (bus.in_valid) begin
                model(bus.alu_control, bus.operand_A, bus.operand_B, mr, mwo, mo, mmu);
                if (mmu) begin
                    m_busy = W;
                    m_pend = mr;
                end else begin
                    m_ov = 1'b1;
                    m_res = mr;
                    if (mwo) m_ovf = mo;
                end
            end
        end
        if (m_live) begin
            chk("sb_in_ready",  bus.in_ready,    (m_busy == 0));
            chk("sb_out_valid", bus.out_valid,   m_ov);
            chk("sb_result",    bus.alu_result,  m_res);
            chk("sb_zero",      bus.zero_flag,   (m_res == 32'h0));
            chk("sb_overflow",  bus.overflow,    m_ovf);
            chk("sb_ram_addr",  bus.ram_address, m_res[AW-1:0]);
        end
    end

    // Issues one op, waits for acceptance and completion. Returns the held outputs, the latency in cycles
    // from the accept cycle, and how many of those cycles had in_ready low. With hold set, a second
    // request is kept pending while the unit is busy.
    task automatic do_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, input bit hold,
                         output logic [31:0] res, output logic ovf, output logic zf,
                         output int lat, output int low);
        bit acc;
        bit got;
        res = 32'h0; ovf = 1'b0; zf = 1'b0; lat = 0; low = 0;
        @(negedge clk);
        bus.in_valid = 1'b1; bus.alu_control = op; bus.operand_A = a; bus.operand_B = b;
        acc = 1'b0;
        for (int n = 0; n < 200; n++) begin
            if (bus.in_ready) begin
                acc = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!acc) begin
            timeout("accept");
            bus.in_valid = 1'b0;
            return;
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.operand_A = ~a; bus.operand_B = ~b;
        lat = 1;
        got = 1'b0;
        for (int n = 0; n < 200; n++) begin
            if (bus.out_valid) begin
                got = 1'b1;
                break;
            end
            if (!bus.in_ready) low++;
            if (hold && lat == 1) begin
                bus.in_valid = 1'b1; bus.alu_control = OP_ADD;
                bus.operand_A = 32'h1; bus.operand_B = 32'h1;
            end
            if (hold && lat == 32) bus.in_valid = 1'b0;
            @(negedge clk);
            lat++;
        end
        bus.in_valid = 1'b0;
        if (!got) begin
            timeout("out_valid");
            return;
        end
        res = bus.alu_result; ovf = bus.overflow; zf = bus.zero_flag;
    endtask

    logic [31:0] r;
    logic        o, z;
    int          lat, low, pulses;
    logic [3:0]  bop [6];
    logic [31:0] ba  [6];
    logic [31:0] bb  [6];
    logic [31:0] bexp[6];

    initial begin
        bus.in_valid = 1'b0; bus.operand_A = 32'h0; bus.operand_B = 32'h0; bus.alu_control = 4'h0;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_in_ready",  bus.in_ready,    1);
        chk("rst_out_valid", bus.out_valid,   0);
        chk("rst_result",    bus.alu_result,  0);
        chk("rst_zero",      bus.zero_flag,   1);
        chk("rst_overflow",  bus.overflow,    0);
        chk("rst_ram_addr",  bus.ram_address, 0);
        reset = 1'b0;

        do_op(OP_ADD, 32'h7FFF_FFFF, 32'h1, 1'b0, r, o, z, lat, low);
        chk("add_result", r, 32'h8000_0000);
        chk("add_ovf", o, 1);
        chk("add_zero", z, 0);
        chk("add_latency", lat, 1);

        do_op(OP_SUB, 32'h8000_0000, 32'h1, 1'b0, r, o, z, lat, low);
        chk("sub_result", r, 32'h7FFF_FFFF);
        chk("sub_ovf", o, 1);

        do_op(OP_SUBU, 32'h3, 32'h3, 1'b0, r, o, z, lat, low);
        chk("subu_result", r, 32'h0);
        chk("subu_zero", z, 1);
        chk("subu_ovf_held", o, 1);

        do_op(OP_SRA, 32'hF000_0000, 32'h4, 1'b0, r, o, z, lat, low);
        chk("sra_result", r, 32'hFF00_0000);
        do_op(OP_SRL, 32'hF000_0000, 32'h4, 1'b0, r, o, z, lat, low);
        chk("srl_result", r, 32'h0F00_0000);
        do_op(OP_SLL, 32'h1, 32'h25, 1'b0, r, o, z, lat, low);
        chk("sll_result", r, 32'h0000_0020);
        do_op(OP_SRA, 32'h8000_0000, 32'h1F, 1'b0, r, o, z, lat, low);
        chk("sra_max_shift", r, 32'hFFFF_FFFF);

        do_op(OP_ADDU, 32'hFFFF_FFFF, 32'h1, 1'b0, r, o, z, lat, low);
        chk("addu_wrap", r, 32'h0);
        chk("addu_ovf_held", o, 1);

        do_op(OP_ADD, 32'h1, 32'h1, 1'b0, r, o, z, lat, low);
        chk("add_no_ovf", o, 0);

        do_op(4'b0000, 32'h1234, 32'h5678, 1'b0, r, o, z, lat, low);
        chk("undef_result", r, 32'h0);

        // Back-to-back single-cycle ops: one result per cycle.
        bop = '{OP_AND, OP_OR, OP_XOR, OP_NOT, OP_NOR, OP_ADDU};
        ba  = '{32'hFF00_FF00, 32'hFF00_FF00, 32'hFF00_FF00, 32'hFF00_FF00, 32'h0, 32'h1234_5678};
        bb  = '{32'h0F0F_0F0F, 32'h0F0F_0F0F, 32'h0F0F_0F0F, 32'h0F0F_0F0F, 32'h0, 32'h1};
        bexp = '{32'h0F00_0F00, 32'hFF0F_FF0F, 32'hF00F_F00F, 32'h00FF_00FF, 32'hFFFF_FFFF, 32'h1234_5679};
        @(negedge clk);
        for (int i = 0; i < 6; i++) begin
            bus.in_valid = 1'b1; bus.alu_control = bop[i]; bus.operand_A = ba[i]; bus.operand_B = bb[i];
            @(negedge clk);
            chk("burst_valid", bus.out_valid, 1);
            chk("burst_result", bus.alu_result, bexp[i]);
        end
        bus.in_valid = 1'b0;
        chk("burst_ram_addr", bus.ram_address, 10'h279);

        do_op(OP_MULU, 32'h0001_0001, 32'h0001_0001, 1'b1, r, o, z, lat, low);
        chk("mulu_result", r, 32'h0002_0001);
        chk("mulu_latency", lat, 33);
        chk("mulu_busy_cycles", low, 32);

        do_op(OP_MULU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, r, o, z, lat, low);
        chk("mulu_max", r, 32'h0000_0001);

`ifdef ALU_DIV_EN
        do_op(OP_DIVU, 32'd100, 32'd7, 1'b0, r, o, z, lat, low);
        chk("divu_result", r, 32'd14);
        chk("divu_latency", lat, 33);
        do_op(OP_DIVU, 32'd5, 32'd0, 1'b0, r, o, z, lat, low);
        chk("divu_by_zero", r, 32'hFFFF_FFFF);
        chk("divu_by_zero_latency", lat, 33);
`else
        do_op(OP_DIVU, 32'd100, 32'd7, 1'b0, r, o, z, lat, low);
        chk("divu_disabled_result", r, 32'h0);
        chk("divu_disabled_latency", lat, 1);
`endif

        // Leave a nonzero result, then reset ten cycles into a multiply.
        do_op(OP_SUB, 32'h8000_0000, 32'h1, 1'b0, r, o, z, lat, low);
        @(negedge clk);
        bus.in_valid = 1'b1; bus.alu_control = OP_MULU; bus.operand_A = 32'h3; bus.operand_B = 32'h5;
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (9) @(negedge clk);
        chk("mid_busy", bus.in_ready, 0);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("abort_in_ready", bus.in_ready, 1);
        chk("abort_result", bus.alu_result, 0);
        chk("abort_zero", bus.zero_flag, 1);
        chk("abort_overflow", bus.overflow, 0);
        pulses = 0;
        for (int n = 0; n < 40; n++) begin
            if (bus.out_valid) pulses++;
            @(negedge clk);
        end
        chk("abort_no_pulse", pulses, 0);

        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog at %0t: simulation did not finish", $time);
        $fatal(1, "watchdog expired");
    end
endmodule
